// File: rtl/mdclcg_bit_packer.sv
// Serial-to-word packer for the dual-CLCG bit stream with a DEPTH-word output FIFO; MDCLCG_MONOBIT_EN adds a popcount health test.
// Latency: word visible 1 cycle after its last bit; backpressure: word_ready, a full FIFO without a pop drops the new word.
module mdclcg_bit_packer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     start,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  output logic [WIDTH-1:0]         word_out,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  output logic [31:0]              ones_total,
  output logic                     bias_alarm
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-2:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      fill_q, fill_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_q, drop_d;

  logic             bit_acc;
  logic             last_bit;
  logic             pop;
  logic             full;
  logic             push_ok;
  logic             drop;
  logic [WIDTH-1:0] word_new;

  always_comb begin
    bit_acc  = bit_valid & ~start;
    last_bit = bit_acc && (cnt_q == CW'(WIDTH - 1));
    word_new = {sreg_q, bit_in};
    pop      = (fill_q != '0) & word_ready & ~start;
    full     = (fill_q == (AW + 1)'(DEPTH));
    // A pop on the same edge frees the slot the new word is written into.
    push_ok  = last_bit & (~full | pop);
    drop     = last_bit & full & ~pop;
  end

  always_comb begin
    cnt_d      = cnt_q;
    sreg_d     = sreg_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;

    if (bit_acc) begin
      sreg_d = {sreg_q[WIDTH-3:0], bit_in};
      cnt_d  = last_bit ? '0 : cnt_q + 1'b1;
    end

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push_ok, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      cnt_q      <= '0;
      sreg_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      sreg_q     <= sreg_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= word_new;
  end

  assign word_valid = (fill_q != '0);
  assign word_out   = word_valid ? mem_q[rd_ptr_q] : '0;
  assign fill_level = fill_q;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_q;

`ifdef MDCLCG_MONOBIT_EN
  localparam int PW = CW + 1;

  logic [PW-1:0] pop_cnt;
  logic          biased;
  logic [31:0]   ones_q, ones_d;
  logic          alarm_q, alarm_d;

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_cnt = pop_cnt + PW'(word_new[i]);
    end
    biased = (pop_cnt < PW'(WIDTH / 8)) || (pop_cnt > PW'(WIDTH - WIDTH / 8));
  end

  always_comb begin
    ones_d  = ones_q;
    alarm_d = alarm_q;
    if (push_ok)           ones_d  = ones_q + 32'(pop_cnt);
    if (last_bit & biased) alarm_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (start) begin
      ones_q  <= '0;
      alarm_q <= 1'b0;
    end else begin
      ones_q  <= ones_d;
      alarm_q <= alarm_d;
    end
  end

  assign ones_total = ones_q;
  assign bias_alarm = alarm_q;
`else
  assign ones_total = '0;
  assign bias_alarm = 1'b0;
`endif

endmodule

// File: tb/tb_mdclcg_bit_packer.sv
// Directed bench for mdclcg_bit_packer; a negedge monitor compares every pop against a scoreboard queue.
module tb_mdclcg_bit_packer;

  logic        clk = 1'b0;
  logic        start;
  logic        bit_in;
  logic        bit_valid;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic [2:0]  fill_level;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic [31:0] ones_total;
  logic        bias_alarm;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  logic [31:0] sb[$];

  mdclcg_bit_packer #(.WIDTH(32), .DEPTH(4)) dut (
    .clk        (clk),
    .start      (start),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .fill_level (fill_level),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .ones_total (ones_total),
    .bias_alarm (bias_alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // A pop happens on the next rising edge whenever valid & ready are seen here.
  always @(negedge clk) begin
    if (!start && word_valid && word_ready) begin
      chk("pop_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        chk("pop_word", word_out, sb.pop_front());
        pops++;
      end
    end
  end

  task automatic do_reset();
    start      = 1'b1;
    bit_valid  = 1'b1;
    bit_in     = 1'b1;
    word_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start     = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    sb.delete();
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input bit ready_last);
    for (int i = 31; i >= 0; i--) begin
      bit_in    = w[i];
      bit_valid = 1'b1;
      if (i == 0 && ready_last) word_ready = 1'b1;
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
      if (i != 0) begin
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_ones1, exp_ones2, exp_alarm;
    int          pops_before;

    start = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; word_ready = 1'b0;

    // Reset values, with bit_valid/word_ready held high during start
    do_reset();
    chk("rst_word_valid", 32'(word_valid), 32'd0);
    chk("rst_fill",       32'(fill_level), 32'd0);
    chk("rst_word_out",   word_out,        32'd0);
    chk("rst_overflow",   32'(overflow),   32'd0);
    chk("rst_drop_cnt",   32'(drop_cnt),   32'd0);
    chk("rst_ones",       ones_total,      32'd0);
    chk("rst_alarm",      32'(bias_alarm), 32'd0);

    // Single word streamed straight through
    word_ready = 1'b1;
    chk("t1_valid_before", 32'(word_valid), 32'd0);
    sb.push_back(32'hA5A50F0F);
    send_word(32'hA5A50F0F, 0, 1'b0);
    @(negedge clk);
    chk("t1_valid_hi",  32'(word_valid), 32'd1);
    chk("t1_fill_1",    32'(fill_level), 32'd1);
    chk("t1_word_out",  word_out,        32'hA5A50F0F);
    @(negedge clk);
    chk("t1_valid_lo",  32'(word_valid), 32'd0);
    chk("t1_fill_0",    32'(fill_level), 32'd0);
    chk("t1_out_empty", word_out,        32'd0);

    // Overflow: fifth word dropped, first four preserved in order
    do_reset();
    word_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) sb.push_back(32'(k));
      send_word(32'(k), 0, 1'b0);
    end
    chk("t2_fill_full", 32'(fill_level), 32'd4);
    chk("t2_overflow",  32'(overflow),   32'd1);
    chk("t2_drop_cnt",  32'(drop_cnt),   32'd1);
    chk("t2_head",      word_out,        32'd1);
    word_ready = 1'b1;
    drain("t2_drain");
    @(negedge clk);
    chk("t2_fill_empty",   32'(fill_level), 32'd0);
    chk("t2_overflow_stk", 32'(overflow),   32'd1);

    // Push and pop on the same edge while full
    do_reset();
    word_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sb.push_back(32'hA0 + 32'(k));
      send_word(32'hA0 + 32'(k), 0, 1'b0);
    end
    chk("t3_fill_pre", 32'(fill_level), 32'd4);
    sb.push_back(32'h12345678);
    send_word(32'h12345678, 0, 1'b1);
    chk("t3_overflow", 32'(overflow),   32'd0);
    chk("t3_fill",     32'(fill_level), 32'd4);
    chk("t3_drop_cnt", 32'(drop_cnt),   32'd0);
    drain("t3_drain");

    // start mid-word discards the partial word
    do_reset();
    word_ready = 1'b1;
    pops_before = pops;
    for (int i = 0; i < 17; i++) begin
      bit_in = 1'b1; bit_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    bit_valid = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back(32'h0000FFFF);
    send_word(32'h0000FFFF, 0, 1'b0);
    drain("t4_drain");
    repeat (5) @(posedge clk);
    #1;
    chk("t4_word_count", 32'(pops - pops_before), 32'd1);

    // bit_valid every third cycle
    do_reset();
    word_ready = 1'b1;
    sb.push_back(32'hDEADBEEF);
    send_word(32'hDEADBEEF, 2, 1'b0);
    @(negedge clk);
    chk("t5_valid", 32'(word_valid), 32'd1);
    chk("t5_word",  word_out,        32'hDEADBEEF);
    drain("t5_drain");

    // Monobit health test
`ifdef MDCLCG_MONOBIT_EN
    exp_ones1 = 32'd1;  exp_ones2 = 32'd17; exp_alarm = 32'd1;
`else
    exp_ones1 = 32'd0;  exp_ones2 = 32'd0;  exp_alarm = 32'd0;
`endif
    do_reset();
    word_ready = 1'b1;
    sb.push_back(32'h00000001);
    send_word(32'h00000001, 0, 1'b0);
    chk("t6_ones_1",  ones_total,      exp_ones1);
    chk("t6_alarm_1", 32'(bias_alarm), exp_alarm);
    sb.push_back(32'h0F0F0F0F);
    send_word(32'h0F0F0F0F, 0, 1'b0);
    chk("t6_ones_2",  ones_total,      exp_ones2);
    chk("t6_alarm_2", 32'(bias_alarm), exp_alarm);
    drain("t6_drain");
    do_reset();
    chk("t6_ones_rst",  ones_total,      32'd0);
    chk("t6_alarm_rst", 32'(bias_alarm), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
